mod_mul_serial: RTL and testbench

- Bit-serial interleaved modular multiplier: computes o_result = (i_a * i_b) mod i_n.
- Forward counterpart of the modular inversion block. Recomputes a product from an inversion result, e.g. b * (a/b mod n) = a.
- Used by the ECC point-arithmetic datapath for field multiplication.
- Processes one multiplier bit per clock, MSB first, with a start/finished handshake matching the inversion block.

---
 rtl/mod_mul_serial.sv | 142 ++++++++++++++
 tb/tb_mod_mul_serial.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_mul_serial.sv
`default_nettype none
// ============================================================================
// Module      : mod_mul_serial
// Description : Bit-serial interleaved modular multiplier.
//               o_result = (i_a * i_b) mod i_n.
//               Scans the multiplier i_b one bit per clock, MSB first.
//               Each step doubles the accumulator and conditionally adds the
//               multiplicand, and each partial result is reduced mod n.
//               The start/finished handshake matches the modular inversion
//               block. That lets a product be recomputed from an inversion
//               result, for example b * (a/b mod n) = a.
// Ports       :
//   i_clk      - clock, rising edge
//   i_rst      - asynchronous active-low reset
//   i_start    - start request, sampled only while idle
//   i_n        - modulus (n >= 1)
//   i_a        - multiplicand (a < n)
//   i_b        - multiplier (any value)
//   o_result   - product mod n, held until the next completion
//   o_finished - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module mod_mul_serial #(
  parameter int MAX_BITS = 256
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [MAX_BITS-1:0] i_n,
  input  logic [MAX_BITS-1:0] i_a,
  input  logic [MAX_BITS-1:0] i_b,
  output logic [MAX_BITS-1:0] o_result,
  output logic                o_finished
);

  localparam int               CW       = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
  localparam logic [CW-1:0]    LAST_IDX = CW'(MAX_BITS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          state_q,    state_d;
  logic [MAX_BITS-1:0] n_q,        n_d;
  logic [MAX_BITS-1:0] a_q,        a_d;
  logic [MAX_BITS-1:0] b_q,        b_d;
  logic [MAX_BITS:0]   r_q,        r_d;
  logic [CW-1:0]       idx_q,      idx_d;
  logic [MAX_BITS-1:0] result_q,   result_d;
  logic                finished_q, finished_d;

  // One interleaved step. The accumulator carries one extra bit so that 2R and
  // T + a, each below 2n when a < n, cannot overflow before reduction.
  logic [MAX_BITS:0] n_ext;
  logic [MAX_BITS:0] dbl;
  logic [MAX_BITS:0] t1;
  logic [MAX_BITS:0] sum;
  logic [MAX_BITS:0] t2;

  always_comb begin
    n_ext = {1'b0, n_q};
    dbl   = r_q << 1;
    t1    = (dbl >= n_ext) ? (dbl - n_ext) : dbl;
    sum   = t1 + {1'b0, a_q};
    if (b_q[idx_q]) begin
      t2 = (sum >= n_ext) ? (sum - n_ext) : sum;
    end else begin
      t2 = t1;
    end
  end

  // Control. The bit counter is not tested for validity anywhere. RUN always
  // takes exactly MAX_BITS cycles, whatever the operand values, so operands
  // that break the preconditions still complete with the normal latency.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    a_d        = a_q;
    b_d        = b_q;
    r_d        = r_q;
    idx_d      = idx_q;
    result_d   = result_q;
    finished_d = finished_q;

    case (state_q)
      S_IDLE: begin
        finished_d = 1'b0;
        if (i_start) begin
          n_d     = i_n;
          a_d     = i_a;
          b_d     = i_b;
          r_d     = '0;
          idx_d   = LAST_IDX;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        r_d = t2;
        if (idx_q == '0) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      S_DONE: begin
        result_d   = r_q[MAX_BITS-1:0];
        finished_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      r_q        <= '0;
      idx_q      <= '0;
      result_q   <= '0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      a_q        <= a_d;
      b_q        <= b_d;
      r_q        <= r_d;
      idx_q      <= idx_d;
      result_q   <= result_d;
      finished_q <= finished_d;
    end
  end

  assign o_result   = result_q;
  assign o_finished = finished_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_mul_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_mul_serial
// Description : Self-checking bench for mod_mul_serial.
//               Instantiates one 8-bit and one 256-bit multiplier.
//               Drivers push the expected results into a scoreboard.
//               Negedge monitors pop and compare the result and the latency
//               on every o_finished pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_mul_serial;

  localparam logic [255:0] P256 =
    256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start8, fin8;
  logic [7:0]   n8, a8, b8, res8;
  logic         start256, fin256;
  logic [255:0] n256, a256, b256, res256;

  mod_mul_serial #(.MAX_BITS(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start8),
    .i_n(n8), .i_a(a8), .i_b(b8),
    .o_result(res8), .o_finished(fin8)
  );

  mod_mul_serial #(.MAX_BITS(256)) dut256 (
    .i_clk(clk), .i_rst(rst), .i_start(start256),
    .i_n(n256), .i_a(a256), .i_b(b256),
    .o_result(res256), .o_finished(fin256)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [255:0] res;
    int           edge0;
  } exp_t;

  exp_t q8[$];
  exp_t q256[$];
  int   pulses8[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  function automatic logic [255:0] mulmod(input logic [255:0] n, input logic [255:0] a,
                                          input logic [255:0] b);
    logic [511:0] p;
    logic [511:0] r;
    p = {256'd0, a} * {256'd0, b};
    r = p % {256'd0, n};
    return r[255:0];
  endfunction

  // Scoreboard monitors
  logic fin8_prev   = 1'b0;
  logic fin256_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      if (fin8) begin
        check("pulse_width8", 256'(fin8_prev), 0);
        pulses8.push_back(cyc);
        if (q8.size() == 0) begin
          check("spurious8", 256'(fin8), 0);
        end else begin
          exp_t e;
          e = q8.pop_front();
          check("result8", 256'(res8), e.res);
          check("latency8", 256'(cyc - e.edge0), 9);
        end
      end
      fin8_prev <= fin8;
    end else begin
      fin8_prev <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (fin256) begin
        check("pulse_width256", 256'(fin256_prev), 0);
        if (q256.size() == 0) begin
          check("spurious256", 256'(fin256), 0);
        end else begin
          exp_t e;
          e = q256.pop_front();
          check("result256", res256, e.res);
          check("latency256", 256'(cyc - e.edge0), 257);
        end
      end
      fin256_prev <= fin256;
    end else begin
      fin256_prev <= 1'b0;
    end
  end

  // Drivers: the start request is seen at the posedge after this negedge,
  // which becomes edge 0 of the operation.
  task automatic go8(input logic [7:0] n, input logic [7:0] a, input logic [7:0] b,
                     input logic [255:0] exp, input bit push);
    @(negedge clk);
    n8 = n; a8 = a; b8 = b; start8 = 1'b1;
    if (push) q8.push_back('{exp, cyc + 1});
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic go256(input logic [255:0] n, input logic [255:0] a, input logic [255:0] b,
                       input logic [255:0] exp);
    @(negedge clk);
    n256 = n; a256 = a; b256 = b; start256 = 1'b1;
    q256.push_back('{exp, cyc + 1});
    @(negedge clk);
    start256 = 1'b0;
  endtask

  task automatic wait8(input int budget);
    int k;
    k = 0;
    while (q8.size() != 0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (q8.size() != 0) begin
      check("timeout8", 256'(q8.size()), 0);
      q8.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait256(input int budget);
    int k;
    k = 0;
    while (q256.size() != 0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (q256.size() != 0) begin
      check("timeout256", 256'(q256.size()), 0);
      q256.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    start8 = 1'b0; n8 = '0; a8 = '0; b8 = '0;
    start256 = 1'b0; n256 = '0; a256 = '0; b256 = '0;
    repeat (3) @(negedge clk);
    check("rst_result8", 256'(res8), 0);
    check("rst_fin8", 256'(fin8), 0);
    check("rst_result256", res256, 0);
    check("rst_fin256", 256'(fin256), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic product and latency
    go8(8'd13, 8'd7, 8'd5, 9, 1'b1);
    wait8(30);
    repeat (5) @(negedge clk);
    check("hold8", 256'(res8), 9);

    // Boundary operands
    go8(8'd251, 8'd250, 8'd250, 1, 1'b1);
    wait8(30);
    go8(8'd251, 8'd0, 8'd200, 0, 1'b1);
    wait8(30);
    go8(8'd1, 8'd0, 8'd255, 0, 1'b1);
    wait8(30);

    // Extra start requests while busy, and operand changes after capture
    go8(8'd13, 8'd7, 8'd5, 9, 1'b1);
    a8 = 8'hFF; b8 = 8'hAA; n8 = 8'd97;
    repeat (1) @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("hold_during_run8", 256'(res8), 0);
    repeat (1) @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait8(30);
    repeat (15) @(negedge clk);

    // Asynchronous reset in the middle of an operation
    go8(8'd13, 8'd7, 8'd5, 0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_fin8", 256'(fin8), 0);
    check("abort_result8", 256'(res8), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    go8(8'd13, 8'd3, 8'd9, 1, 1'b1);
    wait8(30);

    // Start held high: three back-to-back operations
    pulses8.delete();
    @(negedge clk);
    n8 = 8'd13; a8 = 8'd7; b8 = 8'd5; start8 = 1'b1;
    q8.push_back('{mulmod(13, 7, 5), cyc + 1});
    repeat (10) @(negedge clk);
    n8 = 8'd251; a8 = 8'd250; b8 = 8'd250;
    q8.push_back('{mulmod(251, 250, 250), cyc + 1});
    repeat (10) @(negedge clk);
    n8 = 8'd200; a8 = 8'd199; b8 = 8'd3;
    q8.push_back('{mulmod(200, 199, 3), cyc + 1});
    @(negedge clk);
    start8 = 1'b0;
    wait8(40);
    repeat (12) @(negedge clk);
    check("pulse_count8", 256'(pulses8.size()), 3);
    if (pulses8.size() >= 3) begin
      check("spacing8_a", 256'(pulses8[1] - pulses8[0]), 10);
      check("spacing8_b", 256'(pulses8[2] - pulses8[1]), 10);
    end

    // Full-width field products over P-256
    go256(P256, P256 - 256'd1, P256 - 256'd1, 1);
    wait256(300);
    go256(P256, 256'd2, (P256 >> 1) + 256'd1, 1);
    wait256(300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
